seq_gen_controller: RTL and testbench

//  Fills the shared 32x4 sequence RAM with pseudo-random digits when the game controller

---
 rtl/seq_gen_controller.sv | 130 +++++++++++++
 tb/tb_seq_gen_controller.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_gen_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_gen_controller                                                         |
// | Fills the 32x4 sequence RAM with LFSR digits in 1..Max and owns its port.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seq_gen_controller #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter logic [3:0]  MAX_TRIES = 4'd15,
  parameter logic [3:0]  FALLBACK  = 4'd1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       GoGen,
  input  logic [1:0] Diff,
  input  logic [4:0] Stage,
  input  logic [4:0] SeqAddr,
  input  logic [3:0] RAMDataOut,
  output logic [4:0] RAMAddr,
  output logic [3:0] RAMDataIn,
  output logic       RAMWrEn,
  output logic [3:0] RAMOutput,
  output logic       FinGen,
  output logic       Busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAW  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_lfsr;
  logic [4:0]  r_idx;
  logic [4:0]  r_last;
  logic [3:0]  r_tries;
  logic [3:0]  r_max;

  logic        w_fb;
  logic [3:0]  w_cand;
  logic        w_candOk;
  logic [3:0]  w_diffMax;

  assign w_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_cand   = r_lfsr[3:0];
  assign w_candOk = (w_cand != 4'd0) && (w_cand <= r_max);

  always_comb begin
    w_diffMax = 4'd4;
    case (Diff)
      2'b10:   w_diffMax = 4'd6;
      2'b11:   w_diffMax = 4'd9;
      default: w_diffMax = 4'd4;
    endcase
  end

  assign RAMAddr   = Busy ? r_idx : SeqAddr;
  assign RAMOutput = RAMDataOut;

  // Free-running so the player's timing decides where in the sequence a draw lands.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state   <= S_IDLE;
      RAMWrEn   <= 1'b0;
      RAMDataIn <= 4'd0;
      FinGen    <= 1'b0;
      Busy      <= 1'b0;
      r_idx     <= 5'd0;
      r_last    <= 5'd0;
      r_tries   <= 4'd0;
      r_max     <= 4'd4;
    end else begin
      RAMWrEn <= 1'b0;
      FinGen  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (GoGen) begin
            r_max   <= w_diffMax;
            r_last  <= Stage;
            r_idx   <= 5'd0;
            r_tries <= 4'd0;
            Busy    <= 1'b1;
            r_state <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (w_candOk) begin
            RAMDataIn <= w_cand;
            RAMWrEn   <= 1'b1;
            r_state   <= S_WRITE;
          end else if (r_tries == MAX_TRIES) begin
            RAMDataIn <= FALLBACK;
            RAMWrEn   <= 1'b1;
            r_state   <= S_WRITE;
          end else begin
            r_tries <= r_tries + 4'd1;
          end
        end
        S_WRITE: begin
          r_tries <= 4'd0;
          // Compare before incrementing so Stage=31 finishes without Idx wrapping.
          if (r_idx == r_last) begin
            FinGen  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + 5'd1;
            r_state <= S_DRAW;
          end
        end
        S_DONE: begin
          Busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_gen_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seq_gen_controller                                                      |
// | Bench for seq_gen_controller with a cycle schedule model of the generator. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_seq_gen_controller;

  // From this seed the next 16 draws all fall outside 1..4.
  localparam logic [15:0] c_SEED = 16'hA7FF;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       GoGen = 1'b0;
  logic [1:0] Diff = 2'd1;
  logic [4:0] Stage = 5'd0;
  logic [4:0] SeqAddr = 5'd0;
  logic [3:0] RAMDataOut = 4'd0;
  logic [4:0] RAMAddr;
  logic [3:0] RAMDataIn;
  logic       RAMWrEn;
  logic [3:0] RAMOutput;
  logic       FinGen;
  logic       Busy;

  seq_gen_controller #(
    .SEED(c_SEED),
    .MAX_TRIES(4'd15),
    .FALLBACK(4'd1)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .GoGen(GoGen),
    .Diff(Diff),
    .Stage(Stage),
    .SeqAddr(SeqAddr),
    .RAMDataOut(RAMDataOut),
    .RAMAddr(RAMAddr),
    .RAMDataIn(RAMDataIn),
    .RAMWrEn(RAMWrEn),
    .RAMOutput(RAMOutput),
    .FinGen(FinGen),
    .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Model: on a trigger, scan the LFSR stream ahead and lay out, cycle by cycle,
  // where each digit gets written and when the run ends.
  int          cyc = 0;
  logic [15:0] mLfsr = c_SEED;
  int          startCyc = -1;
  int          doneCyc = -1;
  int          mMax = 4;
  int          expAddr[int];
  int          expWr[int];
  bit          armed = 1'b0;

  function automatic void schedule(input int n, input logic [15:0] lf,
                                   input logic [1:0] diff, input logic [4:0] stage);
    int t;
    int tries;
    int d;
    bit got;
    logic [15:0] l;
    l = lf;
    t = n;
    mMax = (diff == 2'd3) ? 9 : (diff == 2'd2) ? 6 : 4;
    for (int i = 0; i <= int'(stage); i++) begin
      tries = 0;
      got = 1'b0;
      d = 0;
      while (!got) begin
        expAddr[t] = i;
        if (l[3:0] >= 4'd1 && int'(l[3:0]) <= mMax) begin
          d = int'(l[3:0]);
          got = 1'b1;
        end else if (tries == 15) begin
          d = 1;
          got = 1'b1;
        end else begin
          tries++;
        end
        t++;
        l = lfsrStep(l);
      end
      expAddr[t] = i;
      expWr[t] = d;
      t++;
      l = lfsrStep(l);
    end
    expAddr[t] = int'(stage);
    startCyc = n;
    doneCyc = t;
  endfunction

  always @(posedge Clk) begin
    cyc = cyc + 1;
    if (Rst) begin
      armed = 1'b1;
      mLfsr = c_SEED;
      startCyc = -1;
      doneCyc = -1;
      expAddr.delete();
      expWr.delete();
    end else begin
      mLfsr = lfsrStep(mLfsr);
      if (armed && GoGen && (cyc - 1) > doneCyc) schedule(cyc, mLfsr, Diff, Stage);
    end
  end

  always @(negedge Clk) RAMDataOut = 4'($urandom);

  int obsWr = 0;
  int obsFin = 0;
  int obsData = 0;
  int finCyc = 0;
  int wrAddrQ[$];
  bit eBusy;
  bit eWr;
  bit eFin;
  int eAddr;

  always @(posedge Clk) begin
    #1;
    if (armed) begin
      eBusy = (startCyc >= 0) && (cyc >= startCyc) && (cyc <= doneCyc);
      eWr   = expWr.exists(cyc);
      eFin  = (cyc == doneCyc);
      eAddr = (eBusy && expAddr.exists(cyc)) ? expAddr[cyc] : int'(SeqAddr);
      chk("Busy", 32'(Busy), 32'(eBusy));
      chk("RAMWrEn", 32'(RAMWrEn), 32'(eWr));
      chk("FinGen", 32'(FinGen), 32'(eFin));
      chk("RAMAddr", 32'(RAMAddr), eAddr);
      chk("RAMOutput", 32'(RAMOutput), 32'(RAMDataOut));
      if (eWr) chk("RAMDataIn", 32'(RAMDataIn), expWr[cyc]);
      if (RAMWrEn === 1'b1) begin
        obsWr++;
        obsData = int'(RAMDataIn);
        wrAddrQ.push_back(int'(RAMAddr));
        chk("wrRange", 32'(RAMDataIn >= 4'd1 && int'(RAMDataIn) <= mMax), 32'd1);
      end
      if (FinGen === 1'b1) begin
        obsFin++;
        finCyc = cyc;
      end
    end
  end

  task automatic clearObs();
    obsWr = 0;
    obsFin = 0;
    obsData = 0;
    wrAddrQ.delete();
  endtask

  task automatic waitFin(input int target, input int budget);
    int k = 0;
    while (obsFin < target && k < budget) begin
      @(negedge Clk);
      k++;
    end
    chk("finTimeout", 32'(obsFin >= target), 32'd1);
  endtask

  task automatic waitWr(input int target, input int budget);
    int k = 0;
    while (obsWr < target && k < budget) begin
      @(negedge Clk);
      k++;
    end
    chk("wrTimeout", 32'(obsWr >= target), 32'd1);
  endtask

  task automatic pulseGo(input logic [1:0] d, input logic [4:0] s);
    repeat (2) @(negedge Clk);
    clearObs();
    Diff = d;
    Stage = s;
    GoGen = 1'b1;
    @(negedge Clk);
    GoGen = 1'b0;
  endtask

  task automatic chkAddrs(input int n);
    chk("wrCount", obsWr, n);
    for (int i = 0; i < n && i < wrAddrQ.size(); i++) chk("wrAddrOrder", wrAddrQ[i], i);
  endtask

  int trig;

  initial begin
    // Reset state and idle address pass-through
    Rst = 1'b1;
    SeqAddr = 5'd7;
    repeat (3) @(negedge Clk);
    #1;
    chk("rstBusy", 32'(Busy), 32'd0);
    chk("rstWrEn", 32'(RAMWrEn), 32'd0);
    chk("rstFin", 32'(FinGen), 32'd0);
    chk("rstDataIn", 32'(RAMDataIn), 32'd0);
    chk("idleAddr", 32'(RAMAddr), 32'd7);

    // Forced fallback: 16 rejected draws straight after reset
    Rst = 1'b0;
    Diff = 2'd1;
    Stage = 5'd0;
    clearObs();
    GoGen = 1'b1;
    trig = cyc + 1;
    @(negedge Clk);
    GoGen = 1'b0;
    waitFin(1, 60);
    chk("fbData", obsData, 1);
    chk("fbWrites", obsWr, 1);
    chk("fbLatency", finCyc - trig, 17);

    // Diff=01, Stage=4, controller address differs from Idx
    SeqAddr = 5'd17;
    pulseGo(2'd1, 5'd4);
    waitFin(1, 200);
    repeat (3) @(negedge Clk);
    chkAddrs(5);
    chk("t1Fin", obsFin, 1);
    chk("t1BusyAfter", 32'(Busy), 32'd0);

    // Diff=11, Stage=31: full RAM, no wrap
    SeqAddr = 5'd3;
    pulseGo(2'd3, 5'd31);
    waitFin(1, 700);
    repeat (3) @(negedge Clk);
    chkAddrs(32);
    chk("t2Fin", obsFin, 1);

    // Diff=00 behaves as 01
    pulseGo(2'd0, 5'd6);
    waitFin(1, 200);
    repeat (3) @(negedge Clk);
    chkAddrs(7);

    // GoGen and input changes mid-run are ignored
    pulseGo(2'd2, 5'd9);
    waitWr(3, 200);
    GoGen = 1'b1;
    Diff = 2'd3;
    Stage = 5'd2;
    @(negedge Clk);
    GoGen = 1'b0;
    waitFin(1, 300);
    repeat (40) @(negedge Clk);
    chkAddrs(10);
    chk("t4Fin", obsFin, 1);

    // GoGen held through DONE re-triggers once more
    repeat (2) @(negedge Clk);
    clearObs();
    Diff = 2'd3;
    Stage = 5'd0;
    GoGen = 1'b1;
    waitFin(1, 60);
    repeat (2) @(negedge Clk);
    GoGen = 1'b0;
    waitFin(2, 60);
    repeat (40) @(negedge Clk);
    chk("holdFin", obsFin, 2);

    // Reset after the third write of a Stage=9 run
    pulseGo(2'd1, 5'd9);
    waitWr(3, 200);
    Rst = 1'b1;
    @(negedge Clk);
    #1;
    chk("abortBusy", 32'(Busy), 32'd0);
    chk("abortWrEn", 32'(RAMWrEn), 32'd0);
    chk("abortFin", 32'(FinGen), 32'd0);
    chk("abortWrites", obsWr, 3);
    chk("abortNoFin", obsFin, 0);
    Rst = 1'b0;
    Diff = 2'd1;
    Stage = 5'd0;
    clearObs();
    GoGen = 1'b1;
    trig = cyc + 1;
    @(negedge Clk);
    GoGen = 1'b0;
    waitFin(1, 60);
    chk("reseedData", obsData, 1);
    chk("reseedLatency", finCyc - trig, 17);

    repeat (5) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
